// File: rtl/duc_sps.sv
`default_nettype none
// ============================================================================
//  Module   : duc_sps
//  Purpose  : Symbol-rate-aware BPSK digital upconverter. Accepts signed
//             baseband symbols over a valid/ready handshake, holds each symbol
//             for SPS carrier strobes and multiplies it by the carrier sample.
//             The output is registered and strobed one cycle after each
//             carrier strobe.
//  Ports    : clk, rst_n (async, active low), clear (sync soft clear)
//             sym_in/sym_valid/sym_ready      : baseband symbol handshake
//             carrier_sig/carrier_vld         : carrier sample and strobe
//             duc_sig/duc_valid               : upconverted sample and strobe
//             underrun                        : no symbol at a symbol boundary
//  Revision : 1.0 - initial release
// ============================================================================
module duc_sps #(
    parameter int BWIDTH = 2,
    parameter int CWIDTH = 16,
    parameter int SPS    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [BWIDTH-1:0] sym_in,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [CWIDTH-1:0] carrier_sig,
    input  logic              carrier_vld,
    output logic [CWIDTH-1:0] duc_sig,
    output logic              duc_valid,
    output logic              underrun
);

    localparam int                 c_CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int                 c_PW    = BWIDTH + CWIDTH;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SPS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        c_IDLE = 1'b0,
        c_RUN  = 1'b1
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [BWIDTH-1:0]   r_sym_q, w_sym_d;
    logic [c_CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [CWIDTH-1:0]   r_duc_sig_q, w_duc_sig_d;
    logic                r_duc_valid_q, w_duc_valid_d;
    logic                r_underrun_q, w_underrun_d;

    logic signed [c_PW-1:0] w_prod;
    logic                   w_boundary;
    logic                   w_unused_lsbs;

    // Both operands are sign-extended to the full product width so the
    // multiply is exact without relying on context-width rules.
    assign w_prod = $signed({{CWIDTH{r_sym_q[BWIDTH-1]}}, r_sym_q})
                  * $signed({{BWIDTH{carrier_sig[CWIDTH-1]}}, carrier_sig});

    // The low BWIDTH product bits are dropped by truncation.
    assign w_unused_lsbs = ^w_prod[BWIDTH-1:0];

    assign w_boundary = carrier_vld && (r_cnt_q == c_LAST);

    always_comb begin
        w_state_d     = r_state_q;
        w_sym_d       = r_sym_q;
        w_cnt_d       = r_cnt_q;
        w_duc_valid_d = carrier_vld;
        w_duc_sig_d   = carrier_vld ? w_prod[c_PW-1:BWIDTH] : r_duc_sig_q;
        w_underrun_d  = 1'b0;
        sym_ready     = 1'b0;

        if (clear) begin
            // Clear wins over both the handshake and the strobe; the output
            // sample is left untouched, only its strobe is suppressed.
            w_state_d     = c_IDLE;
            w_sym_d       = '0;
            w_cnt_d       = '0;
            w_duc_valid_d = 1'b0;
            w_duc_sig_d   = r_duc_sig_q;
        end else begin
            case (r_state_q)
                c_IDLE: begin
                    // sym_reg is zero here, so IDLE strobes emit zero samples.
                    sym_ready = 1'b1;
                    if (sym_valid) begin
                        w_sym_d   = sym_in;
                        w_cnt_d   = '0;
                        w_state_d = c_RUN;
                    end
                end
                c_RUN: begin
                    sym_ready = w_boundary;
                    if (carrier_vld) begin
                        if (w_boundary) begin
                            w_cnt_d = '0;
                            if (sym_valid) begin
                                w_sym_d = sym_in;
                            end else begin
                                w_sym_d      = '0;
                                w_state_d    = c_IDLE;
                                w_underrun_d = 1'b1;
                            end
                        end else begin
                            w_cnt_d = r_cnt_q + c_ONE;
                        end
                    end
                end
                default: begin
                    w_state_d = c_IDLE;
                    w_sym_d   = '0;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= c_IDLE;
            r_sym_q       <= '0;
            r_cnt_q       <= '0;
            r_duc_sig_q   <= '0;
            r_duc_valid_q <= 1'b0;
            r_underrun_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_sym_q       <= w_sym_d;
            r_cnt_q       <= w_cnt_d;
            r_duc_sig_q   <= w_duc_sig_d;
            r_duc_valid_q <= w_duc_valid_d;
            r_underrun_q  <= w_underrun_d;
        end
    end

    assign duc_sig   = r_duc_sig_q;
    assign duc_valid = r_duc_valid_q;
    assign underrun  = r_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_duc_sps.sv
`default_nettype none
// ============================================================================
//  Module   : tb_duc_sps
//  Purpose  : Self-checking bench for duc_sps (BWIDTH=2, CWIDTH=16, SPS=4).
//             A driver applies directed and random stimulus at the falling
//             edge and feeds a symbol-level reference model; expected samples
//             are queued and a monitor compares them after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_duc_sps;

    localparam int BW  = 2;
    localparam int CW  = 16;
    localparam int SPS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [BW-1:0] sym_in = '0;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic [CW-1:0] carrier_sig = '0;
    logic          carrier_vld = 1'b0;
    logic [CW-1:0] duc_sig;
    logic          duc_valid;
    logic          underrun;

    duc_sps #(
        .BWIDTH (BW),
        .CWIDTH (CW),
        .SPS    (SPS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .sym_in      (sym_in),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .carrier_sig (carrier_sig),
        .carrier_vld (carrier_vld),
        .duc_sig     (duc_sig),
        .duc_valid   (duc_valid),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Scoreboard and expectations shared between driver and monitor
    logic [CW-1:0] exp_q[$];
    logic          exp_valid = 1'b0;
    logic          exp_ur    = 1'b0;
    logic          rdy_exp   = 1'b0;
    logic          rdy_act   = 1'b0;
    logic          rdy_chk   = 1'b0;
    logic          tb_done   = 1'b0;
    logic          end_checked = 1'b0;
    int            total = 0;
    int            bad   = 0;

    // Reference model: symbol currently on air and strobes left in it
    bit            m_active = 1'b0;
    logic [BW-1:0] m_cur    = '0;
    int            m_left   = 0;

    // Exact product scaled down by 2^BW, rounded toward minus infinity
    function automatic logic [CW-1:0] mix(input logic [BW-1:0] s, input logic [CW-1:0] c);
        int sv;
        int cv;
        int r;
        sv = $signed(s);
        cv = $signed(c);
        r  = (sv * cv) >>> BW;
        return r[CW-1:0];
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_cur    = '0;
        m_left   = 0;
        exp_q.delete();
        exp_valid = 1'b0;
        exp_ur    = 1'b0;
        rdy_chk   = 1'b0;
    endtask

    task automatic do_cycle(input bit clr, input bit sv, input logic [BW-1:0] s,
                            input bit cv, input logic [CW-1:0] car);
        @(negedge clk);
        clear       = clr;
        sym_valid   = sv;
        sym_in      = s;
        carrier_vld = cv;
        carrier_sig = car;
        #1;
        rdy_act = sym_ready;
        if (clr) begin
            rdy_exp   = 1'b0;
            exp_valid = 1'b0;
            exp_ur    = 1'b0;
            m_active  = 1'b0;
            m_cur     = '0;
            m_left    = 0;
        end else begin
            rdy_exp   = !m_active || (cv && m_left == 1);
            exp_valid = cv;
            exp_ur    = 1'b0;
            if (cv) exp_q.push_back(mix(m_active ? m_cur : '0, car));
            if (!m_active) begin
                if (sv) begin
                    m_active = 1'b1;
                    m_cur    = s;
                    m_left   = SPS;
                end
            end else if (cv) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (sv) begin
                        m_cur  = s;
                        m_left = SPS;
                    end else begin
                        m_active = 1'b0;
                        exp_ur   = 1'b1;
                    end
                end
            end
        end
        rdy_chk = 1'b1;
    endtask

    // Reset pulse dropped between clock edges
    task automatic async_reset();
        #2;
        rst_n       = 1'b0;
        clear       = 1'b0;
        sym_valid   = 1'b0;
        carrier_vld = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: the only process that counts comparisons
    initial begin : p_monitor
        logic [CW-1:0] hold;
        logic [CW-1:0] e;
        hold = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                hold  = '0;
                total = total + 1;
                if (duc_sig !== '0 || duc_valid !== 1'b0 || underrun !== 1'b0) begin
                    bad = bad + 1;
                    $display("FAIL reset_outputs: got sig=%h valid=%b underrun=%b, want 0/0/0",
                             duc_sig, duc_valid, underrun);
                end
                total = total + 1;
                if (sym_ready !== !clear) begin
                    bad = bad + 1;
                    $display("FAIL reset_ready: got %b want %b", sym_ready, !clear);
                end
            end else begin
                if (rdy_chk) begin
                    total = total + 1;
                    if (rdy_act !== rdy_exp) begin
                        bad = bad + 1;
                        $display("FAIL sym_ready @%0t: got %b want %b", $time, rdy_act, rdy_exp);
                    end
                end
                total = total + 1;
                if (duc_valid !== exp_valid) begin
                    bad = bad + 1;
                    $display("FAIL duc_valid @%0t: got %b want %b", $time, duc_valid, exp_valid);
                end
                total = total + 1;
                if (underrun !== exp_ur) begin
                    bad = bad + 1;
                    $display("FAIL underrun @%0t: got %b want %b", $time, underrun, exp_ur);
                end
                if (duc_valid === 1'b1) begin
                    total = total + 1;
                    if (exp_q.size() == 0) begin
                        bad = bad + 1;
                        $display("FAIL duc_sig @%0t: got unexpected sample %h, want none", $time, duc_sig);
                    end else begin
                        e    = exp_q.pop_front();
                        hold = e;
                        if (duc_sig !== e) begin
                            bad = bad + 1;
                            $display("FAIL duc_sig @%0t: got %h want %h", $time, duc_sig, e);
                        end
                    end
                end else begin
                    total = total + 1;
                    if (duc_sig !== hold) begin
                        bad = bad + 1;
                        $display("FAIL duc_sig_hold @%0t: got %h want %h", $time, duc_sig, hold);
                    end
                end
                if (tb_done && !end_checked) begin
                    end_checked = 1'b1;
                    total = total + 1;
                    if (exp_q.size() != 0) begin
                        bad = bad + 1;
                        $display("FAIL drain: got %0d pending samples, want 0", exp_q.size());
                    end
                end
            end
        end
    end

    initial begin : p_driver
        bit            cv;
        bit            sv;
        bit            clr;
        logic [BW-1:0] s;
        logic [CW-1:0] car;

        // Reset held over a few edges, then released with the block idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with carrier running: zero samples every strobe
        repeat (6) do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);

        // Single +1 symbol followed by underrun
        do_cycle(1'b0, 1'b1, 2'b01, 1'b1, 16'h4000);
        repeat (7) do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);

        // Back-to-back -1 then +1, sym_valid held high until the second symbol is taken
        do_cycle(1'b0, 1'b1, 2'b11, 1'b1, 16'h4000);
        repeat (4) do_cycle(1'b0, 1'b1, 2'b01, 1'b1, 16'h4000);
        repeat (6) do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);

        // Sparse strobes, every third cycle
        do_cycle(1'b0, 1'b1, 2'b11, 1'b0, 16'h7FFF);
        for (int i = 0; i < 15; i++)
            do_cycle(1'b0, 1'b0, 2'b00, (i % 3) == 0, 16'h7FFF);

        // Clear on the second strobe of a symbol with a new symbol offered
        do_cycle(1'b0, 1'b1, 2'b01, 1'b0, 16'h4000);
        do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);
        do_cycle(1'b1, 1'b1, 2'b11, 1'b1, 16'h4000);
        repeat (4) do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);

        // Asynchronous reset in the middle of a symbol
        do_cycle(1'b0, 1'b1, 2'b11, 1'b1, 16'h4000);
        repeat (2) do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);
        async_reset();
        repeat (4) do_cycle(1'b0, 1'b0, 2'b00, 1'b1, 16'h4000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cv  = ($urandom % 10) < 6;
            sv  = ($urandom % 10) < 7;
            clr = ($urandom % 40) == 0;
            s   = BW'($urandom);
            car = CW'($urandom);
            do_cycle(clr, sv, s, cv, car);
            if (($urandom % 400) == 0) async_reset();
        end

        // Drain and final check
        repeat (3) do_cycle(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000);
        tb_done = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
